// File: rtl/dl_pkg.sv
// ============================================================================
// Module      : dl_pkg
// Description : Shared types and constants for the ROM download sequencer:
//               region encoding and address map, default image size and
//               the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dl_pkg;

  // Region index; the one-hot write select uses this value as bit position.
  typedef enum logic [1:0] {
    REGION_PROG  = 2'd0,
    REGION_SND   = 2'd1,
    REGION_PROM  = 2'd2,
    REGION_SPARE = 2'd3
  } region_e;

  localparam logic [15:0] PROG_BASE  = 16'h0000;
  localparam logic [15:0] PROG_END   = 16'hBFFF;
  localparam logic [15:0] SND_BASE   = 16'hC000;
  localparam logic [15:0] SND_END    = 16'hCFFF;
  localparam logic [15:0] PROM_BASE  = 16'hD000;
  localparam logic [15:0] PROM_END   = 16'hD0FF;
  localparam logic [15:0] SPARE_BASE = 16'hD100;
  localparam logic [15:0] SPARE_END  = 16'hD1FF;

  localparam logic [16:0] TOTAL_SIZE_DEFAULT = 17'h0D200;
  localparam logic [16:0] COUNT_MAX          = 17'h1FFFF;

  typedef enum logic [2:0] {
    WAIT_DL = 3'd0,
    LOAD    = 3'd1,
    DRAIN   = 3'd2,
    SETTLE  = 3'd3,
    RUN     = 3'd4
  } state_e;

  function automatic logic [3:0] region_onehot(input region_e r);
    return 4'b0001 << r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dl_region_decode.sv
// ============================================================================
// Module      : dl_region_decode
// Description : Combinational address map. Maps an image byte address onto
//               a one-hot region select and the offset inside that region.
// Ports       : addr     - image byte address
//               in_range - address falls inside one of the four regions
//               sel      - one-hot select ([0] PROG .. [3] SPARE), 0 if none
//               offset   - addr minus the region base, 0 if none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dl_region_decode
  import dl_pkg::*;
(
  input  logic [15:0] addr,
  output logic        in_range,
  output logic [3:0]  sel,
  output logic [15:0] offset
);

  // Regions are contiguous and ascending, so an upper-bound chain suffices.
  always_comb begin
    in_range = 1'b1;
    sel      = 4'b0000;
    offset   = 16'h0000;
    if (addr <= PROG_END) begin
      sel    = region_onehot(REGION_PROG);
      offset = addr - PROG_BASE;
    end else if (addr <= SND_END) begin
      sel    = region_onehot(REGION_SND);
      offset = addr - SND_BASE;
    end else if (addr <= PROM_END) begin
      sel    = region_onehot(REGION_PROM);
      offset = addr - PROM_BASE;
    end else if (addr <= SPARE_END) begin
      sel    = region_onehot(REGION_SPARE);
      offset = addr - SPARE_BASE;
    end else begin
      in_range = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/download_sequencer.sv
// ============================================================================
// Module      : download_sequencer
// Description : Steers a serial ROM image download into a one-entry write
//               buffer feeding a shared ROM write port, counts accepted
//               bytes, and holds the game core in reset until the download
//               has drained and a settle period has elapsed.
// Ports       : clk_sys, reset_n (async, active low)
//               dn_download/dn_wr/dn_addr/dn_data - download byte stream
//               wr_valid/wr_ready/wr_sel/wr_addr/wr_data - ROM write port
//               core_reset - reset to the game core
//               size_ok    - last download delivered exactly TOTAL_SIZE bytes
//               overflow   - sticky: a byte was dropped on a busy write port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module download_sequencer
  import dl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [16:0] TOTAL_SIZE  = TOTAL_SIZE_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [3:0]  wr_sel,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        core_reset,
  output logic        size_ok,
  output logic        overflow
);

  localparam int unsigned      HOLD_W    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

  state_e              state_q, state_d;
  logic                dl_prev_q;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [16:0]         count_q, count_d;
  logic                size_ok_q, size_ok_d;
  logic                overflow_q, overflow_d;
  logic                wr_valid_q, wr_valid_d;
  logic [3:0]          wr_sel_q, wr_sel_d;
  logic [15:0]         wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;

  logic                dec_in_range;
  logic [3:0]          dec_sel;
  logic [15:0]         dec_offset;
  logic                dl_rise;
  logic                dl_fall;
  logic                byte_req;

  dl_region_decode u_decode (
    .addr     (dn_addr),
    .in_range (dec_in_range),
    .sel      (dec_sel),
    .offset   (dec_offset)
  );

  assign dl_rise  = dn_download & ~dl_prev_q;
  assign dl_fall  = ~dn_download & dl_prev_q;
  // A strobe in the cycle dn_download falls is still in LOAD, so it counts.
  assign byte_req = (state_q == LOAD) && dn_wr && dec_in_range;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    count_d    = count_q;
    size_ok_d  = size_ok_q;
    overflow_d = overflow_q;
    wr_valid_d = wr_valid_q;
    wr_sel_d   = wr_sel_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    // Buffer drains on handshake; select is zeroed so it never shows stale.
    if (wr_valid_q && wr_ready) begin
      wr_valid_d = 1'b0;
      wr_sel_d   = 4'b0000;
    end

    // A byte may refill the buffer in the same cycle the old one leaves.
    if (byte_req) begin
      if (!wr_valid_q || wr_ready) begin
        wr_valid_d = 1'b1;
        wr_sel_d   = dec_sel;
        wr_addr_d  = dec_offset;
        wr_data_d  = dn_data;
        if (count_q != COUNT_MAX) begin
          count_d = count_q + 17'd1;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end

    case (state_q)
      WAIT_DL, RUN: begin
        if (dl_rise) begin
          state_d    = LOAD;
          count_d    = '0;
          size_ok_d  = 1'b0;
          overflow_d = 1'b0;
        end
      end
      LOAD: begin
        if (dl_fall) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // No bytes are accepted here, so count_q is already final.
        if (!wr_valid_q) begin
          state_d    = SETTLE;
          hold_cnt_d = '0;
          size_ok_d  = (count_q == TOTAL_SIZE);
        end
      end
      SETTLE: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_DL;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_DL;
      dl_prev_q  <= 1'b0;
      hold_cnt_q <= '0;
      count_q    <= '0;
      size_ok_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_sel_q   <= 4'b0000;
      wr_addr_q  <= 16'h0000;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      dl_prev_q  <= dn_download;
      hold_cnt_q <= hold_cnt_d;
      count_q    <= count_d;
      size_ok_q  <= size_ok_d;
      overflow_q <= overflow_d;
      wr_valid_q <= wr_valid_d;
      wr_sel_q   <= wr_sel_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_sel     = wr_sel_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign size_ok    = size_ok_q;
  assign overflow   = overflow_q;
  // Core is released only in RUN; leaving RUN re-asserts it next cycle.
  assign core_reset = (state_q != RUN);

endmodule

`default_nettype wire

// File: tb/tb_download_sequencer.sv
// ============================================================================
// Module      : tb_download_sequencer
// Description : Self-checking bench for download_sequencer. Stimulus pushes
//               expected writes into a scoreboard from a behavioural model;
//               a negedge monitor pops and compares each presented write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_download_sequencer;

  localparam int unsigned HOLD  = 16;
  localparam logic [16:0] TOTAL = 17'h0D200;

  localparam int RBASE [4] = '{'h0000, 'hC000, 'hD000, 'hD100};
  localparam int RSIZE [4] = '{'hC000, 'h1000, 'h0100, 'h0100};

  logic        clk_sys     = 1'b0;
  logic        reset_n     = 1'b0;
  logic        dn_download = 1'b0;
  logic        dn_wr       = 1'b0;
  logic [15:0] dn_addr     = 16'h0000;
  logic [7:0]  dn_data     = 8'h00;
  logic        wr_ready    = 1'b1;
  logic        wr_valid;
  logic [3:0]  wr_sel;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_reset;
  logic        size_ok;
  logic        overflow;

  download_sequencer #(
    .HOLD_CYCLES (HOLD),
    .TOTAL_SIZE  (TOTAL)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .dn_download (dn_download),
    .dn_wr       (dn_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .core_reset  (core_reset),
    .size_ok     (size_ok),
    .overflow    (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Behavioural model: whether a download is being taken, whether the
  // one-byte port buffer is occupied, bytes accepted, sticky drop flag.
  logic        m_loading  = 1'b0;
  logic        m_pend     = 1'b0;
  logic        m_prev_dl  = 1'b0;
  logic        m_overflow = 1'b0;
  logic [16:0] m_count    = '0;

  function automatic void expect_map(input logic [15:0] a, output logic [3:0] sel,
                                     output logic [15:0] off, output logic hit);
    sel = 4'b0000;
    off = 16'h0000;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (int'(a) >= RBASE[i] && int'(a) < RBASE[i] + RSIZE[i]) begin
        sel = 4'(1 << i);
        off = 16'(int'(a) - RBASE[i]);
        hit = 1'b1;
      end
    end
  endfunction

  // Drive one cycle of inputs, then advance the model by the same edge.
  task automatic step(input logic dl, input logic wr, input logic [15:0] a,
                      input logic [7:0] d, input logic rdy);
    logic [3:0]  es;
    logic [15:0] eo;
    logic        hit;
    dn_download = dl;
    dn_wr       = wr;
    dn_addr     = a;
    dn_data     = d;
    wr_ready    = rdy;
    @(posedge clk_sys);
    #1;
    expect_map(a, es, eo, hit);
    if (m_loading && wr && hit && (!m_pend || rdy)) begin
      sb.push_back('{sel: es, addr: eo, data: d, cyc: cyc});
      if (m_count != 17'h1FFFF) m_count++;
      m_pend = 1'b1;
    end else begin
      if (m_loading && wr && hit) m_overflow = 1'b1;
      m_pend = m_pend && !rdy;
    end
    if (dl && !m_prev_dl && !m_loading) begin
      m_loading  = 1'b1;
      m_count    = '0;
      m_overflow = 1'b0;
    end else if (!dl) begin
      m_loading = 1'b0;
    end
    m_prev_dl = dl;
  endtask

  // Drop dn_download and count cycles until the core leaves reset. With an
  // empty buffer: edge 1 sees the fall, edge 2 ends the drain, then HOLD
  // settle cycles, so core_reset is first seen low after HOLD+2 edges.
  task automatic wait_run(output int n);
    n = 0;
    do begin
      step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      n++;
    end while (core_reset && n < 200);
    if (core_reset) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: core_reset still high after %0d cycles", n);
    end
  endtask

  function automatic bit near(input int a);
    return (a < 32) || (a >= 'hBFF0 && a < 'hC010) || (a >= 'hCFF0 && a < 'hD010) ||
           (a >= 'hD0F0 && a < 'hD110) || (a >= 'hD1F0);
  endfunction

  // Monitor: pop on first presentation, then check the port holds steady.
  logic        presented = 1'b0;
  logic [27:0] held      = '0;
  exp_t        cur;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      presented = 1'b0;
    end else if (wr_valid) begin
      if (!presented) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr 0x%0h sel 0x%0h, expected none", wr_addr, wr_sel);
        end else begin
          cur = sb.pop_front();
          chk("wr_sel", 32'(wr_sel), 32'(cur.sel));
          chk("wr_addr", 32'(wr_addr), 32'(cur.addr));
          chk("wr_data", 32'(wr_data), 32'(cur.data));
          chk("latency_cycle", 32'(cyc), 32'(cur.cyc));
        end
        held      = {wr_sel, wr_addr, wr_data};
        presented = 1'b1;
      end else begin
        chk("port_stable", 32'({wr_sel, wr_addr, wr_data}), 32'(held));
      end
      if (wr_ready) presented = 1'b0;
    end else begin
      chk("idle_sel_zero", 32'(wr_sel), 32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int low;

    // Reset and idle
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_core_reset", 32'(core_reset), 32'h1);
    chk("rst_wr_valid", 32'(wr_valid), 32'h0);
    chk("rst_wr_sel", 32'(wr_sel), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_size_ok", 32'(size_ok), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    reset_n = 1'b1;
    repeat (100) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    chk("idle_core_reset", 32'(core_reset), 32'h1);
    chk("idle_wr_valid", 32'(wr_valid), 32'h0);
    chk("idle_size_ok", 32'(size_ok), 32'h0);

    // Full image; 4-cycle strobe spacing around region edges, back-to-back
    // elsewhere so the run stays short. One stray byte at 0xD200 mid-image.
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    for (int a = 0; a < 'hD200; a++) begin
      step(1'b1, 1'b1, 16'(a), 8'($urandom), 1'b1);
      if (a == 'hC005) begin
        chk("c005_valid", 32'(wr_valid), 32'h1);
        chk("c005_sel", 32'(wr_sel), 32'h2);
        chk("c005_addr", 32'(wr_addr), 32'h5);
      end
      if (a == 'h8000) begin
        step(1'b1, 1'b1, 16'hD200, 8'hA5, 1'b1);
        chk("d200_no_valid", 32'(wr_valid), 32'h0);
      end
      if (near(a)) repeat (3) step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    end
    repeat (4) step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    wait_run(n);
    chk("full_hold_cycles", 32'(n - 2), 32'(HOLD));
    chk("full_size_ok", 32'(size_ok), 32'h1);
    chk("full_overflow", 32'(overflow), 32'h0);

    // Re-download from RUN, with a stalled port and a dropped byte
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    chk("rerun_core_reset", 32'(core_reset), 32'h1);
    chk("rerun_size_ok_clr", 32'(size_ok), 32'h0);
    step(1'b1, 1'b1, 16'h0100, 8'h3C, 1'b0);
    chk("stall_first_valid", 32'(wr_valid), 32'h1);
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    step(1'b1, 1'b1, 16'h0101, 8'hC3, 1'b0);
    chk("stall_overflow", 32'(overflow), 32'h1);
    repeat (3) step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    chk("stall_addr_held", 32'(wr_addr), 32'h0100);
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    step(1'b1, 1'b1, 16'hD200, 8'h77, 1'b1);
    chk("d200_no_valid2", 32'(wr_valid), 32'h0);
    step(1'b1, 1'b1, 16'hC123, 8'($urandom), 1'b1);
    step(1'b1, 1'b1, 16'hD0AA, 8'($urandom), 1'b1);
    step(1'b1, 1'b1, 16'hD1FF, 8'($urandom), 1'b1);
    repeat (2) step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    wait_run(n);
    chk("stall_hold_cycles", 32'(n - 2), 32'(HOLD));
    chk("stall_overflow_end", 32'(overflow), 32'(m_overflow));
    chk("stall_size_ok", 32'(size_ok), 32'(m_count == TOTAL));

    // Randomised download against the model
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    chk("load_clears_overflow", 32'(overflow), 32'h0);
    repeat (400) step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 'hD27F)),
                      8'($urandom), 1'($urandom_range(0, 3) != 0));
    repeat (2) step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    wait_run(n);
    chk("rand_overflow", 32'(overflow), 32'(m_overflow));
    chk("rand_size_ok", 32'(size_ok), 32'(m_count == TOTAL));

    // Reset pulsed mid-download
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    step(1'b1, 1'b1, 16'h0200, 8'h5A, 1'b0);
    step(1'b1, 1'b1, 16'h0201, 8'hA5, 1'b0);
    chk("mid_overflow", 32'(overflow), 32'h1);
    #2;
    reset_n     = 1'b0;
    dn_download = 1'b0;
    dn_wr       = 1'b0;
    #1;
    chk("mid_rst_core_reset", 32'(core_reset), 32'h1);
    chk("mid_rst_wr_valid", 32'(wr_valid), 32'h0);
    chk("mid_rst_wr_sel", 32'(wr_sel), 32'h0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'h0);
    chk("mid_rst_size_ok", 32'(size_ok), 32'h0);
    sb.delete();
    m_loading  = 1'b0;
    m_pend     = 1'b0;
    m_prev_dl  = 1'b0;
    m_overflow = 1'b0;
    m_count    = '0;
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    low = 0;
    repeat (40) begin
      step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      if (!core_reset) low++;
    end
    chk("no_run_after_abort", 32'(low), 32'h0);
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'(16'hCFFE + i), 8'($urandom), 1'b1);
    repeat (2) step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    wait_run(n);
    chk("post_abort_hold_cycles", 32'(n - 2), 32'(HOLD));
    chk("post_abort_size_ok", 32'(size_ok), 32'(m_count == TOTAL));

    repeat (3) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/download_sequencer.md
DOWNLOAD_SEQUENCER -- requirements
Module: download_sequencer

Interface
REQ-001 Parameter: HOLD_CYCLES, default 16, number of clk_sys cycles core_reset stays high after a download has drained.
REQ-002 Parameter: TOTAL_SIZE, default 17'h0D200, expected byte count of a complete ROM image.
REQ-003 clk_sys  in  1  single system clock; all logic is clocked on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 dn_download  in  1  ROM download in progress.
REQ-006 dn_wr  in  1  one-cycle byte strobe.
REQ-007 dn_addr  in  16  image byte address.
REQ-008 dn_data  in  8  image byte.
REQ-009 wr_valid  out  1  the shared ROM write port holds a byte.
REQ-010 wr_ready  in  1  the target region accepted the byte this cycle.
REQ-011 wr_sel  out  4  one-hot region select: [0] PROG, [1] SND, [2] PROM, [3] SPARE.
REQ-012 wr_addr  out  16  byte offset within the selected region.
REQ-013 wr_data  out  8  byte to write.
REQ-014 core_reset  out  1  active-high reset to the game core.
REQ-015 size_ok  out  1  the last download delivered exactly TOTAL_SIZE accepted bytes.
REQ-016 overflow  out  1  sticky flag: a byte was dropped because the write port was busy.

Function
REQ-017 The block shall implement the states WAIT_DL, LOAD, DRAIN, SETTLE and RUN.
REQ-018 WAIT_DL -> LOAD on the rising edge of dn_download; core_reset=1.
REQ-019 LOAD -> DRAIN on the falling edge of dn_download; core_reset=1.
REQ-020 DRAIN -> SETTLE in the first cycle with wr_valid=0; core_reset=1.
REQ-021 SETTLE counts HOLD_CYCLES cycles, then goes to RUN; core_reset=1 throughout.
REQ-022 RUN: core_reset=0; a rising edge of dn_download -> LOAD, and core_reset=1 in the next cycle.
REQ-023 Region decode on dn_addr:
- PROG: 0x0000-0xBFFF, base 0x0000.
- SND: 0xC000-0xCFFF, base 0xC000.
- PROM: 0xD000-0xD0FF, base 0xD000.
- SPARE: 0xD100-0xD1FF, base 0xD100.
- wr_addr = dn_addr minus the region base.
REQ-024 Address 0xD200 or higher: the byte is dropped, wr_valid is not set, and the byte is not counted.
REQ-025 In LOAD, dn_wr with the buffer empty (or emptying this cycle through wr_ready) loads the buffer; wr_valid=1 in the next cycle (latency 1).
REQ-026 wr_valid, wr_sel, wr_addr and wr_data shall hold stable until the cycle in which wr_ready=1; wr_valid then clears unless a new byte is loaded in the same cycle.
REQ-027 dn_wr while wr_valid=1 and wr_ready=0: the byte is dropped, not counted, and overflow is set.
REQ-028 dn_wr outside LOAD shall be ignored.
REQ-029 Byte counter:
- 17-bit, cleared on entry to LOAD.
- Increments once per byte accepted into the buffer.
- Saturates at 17'h1FFFF.
REQ-030 size_ok = (count == TOTAL_SIZE):
- Updated on entry to SETTLE.
- Cleared on entry to LOAD.
REQ-031 overflow is cleared only on entry to LOAD, or by reset.
REQ-032 wr_sel shall be 4'b0000 whenever wr_valid=0.
REQ-033 A falling edge of dn_download in the same cycle as a dn_wr shall still accept that byte.

Reset
REQ-034 reset_n low shall asynchronously force:
- state=WAIT_DL, core_reset=1
- wr_valid=0, wr_sel=0, wr_addr=0, wr_data=0
- size_ok=0, overflow=0
- counter=0, edge-detect register=0.
REQ-035 reset_n asserted during LOAD shall abandon the download; the block returns to WAIT_DL and does not enter RUN until a complete new download cycle.

Structure
REQ-036 A shared package dl_pkg shall hold:
- region enum (PROG, SND, PROM, SPARE)
- region base and end constants
- TOTAL_SIZE default
- state enum.
REQ-037 One sub-module, dl_region_decode, shall map the combinational address to the one-hot select and the offset; the FSM, buffer and counter stay in download_sequencer.

Verification
REQ-038 The bench shall cover these directed scenarios:
- Reset, then idle for 100 cycles -> core_reset=1, wr_valid=0, size_ok=0.
- Full image of 0xD200 bytes, strobes every 4 cycles, wr_ready always high -> each byte appears 1 cycle later with the correct sel; byte 0xC005 gives sel=0010, addr=0x0005; size_ok=1; core_reset falls exactly HOLD_CYCLES cycles after the drain.
- wr_ready held low for 6 cycles while 2 strobes arrive -> the second byte is dropped, overflow=1, count one short, size_ok=0.
- Byte at address 0xD200 -> no wr_valid, count unchanged.
- dn_download re-asserted in RUN -> core_reset=1 next cycle; overflow and size_ok cleared.
- reset_n pulsed low mid-LOAD -> outputs take reset values immediately; no RUN until the next complete download.
